// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared defaults, constants and stage types for the vertical scaler
package scaler_pkg;

  localparam int PIXEL_STEP_DEF  = 4096;
  localparam int PIXEL_WIDTH_DEF = 12;
  localparam int COE_WIDTH_DEF   = 10;
  localparam int LINE_MAX_DEF    = 4096;
  localparam int POS_W           = 24;

  localparam int COE_ONE_DEF   = 1 << (COE_WIDTH_DEF - 1);
  localparam int ROUND_ADD_DEF = 1 << (COE_WIDTH_DEF - 2);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic int coe_one(input int cw);
    return 1 << (cw - 1);
  endfunction

  function automatic int round_add(input int cw);
    return 1 << (cw - 2);
  endfunction

endpackage

// File: rtl/scaler_line_ram.sv
// rtl/scaler_line_ram.sv - simple dual-port line buffer, 1-cycle read, read-before-write
module scaler_line_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 12,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/scaler_v.sv
// rtl/scaler_v.sv - vertical linear downscaler, single line buffer, fixed 4-cycle latency
// Optional macro SCALER_V_TOP_ALIGN_EN: emit input line 0 of each frame as a pure copy.
module scaler_v
  import scaler_pkg::*;
#(
  parameter int PIXEL_STEP  = PIXEL_STEP_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int COE_WIDTH   = COE_WIDTH_DEF,
  parameter int LINE_MAX    = LINE_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            scale_step_v,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   line_ovf_o
);

  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int SH = $clog2(PIXEL_STEP) - COE_WIDTH + 1;
  localparam int PW = PIXEL_WIDTH + COE_WIDTH;
  localparam int SW = PW + 1;
  localparam logic [POS_W-1:0]     STEP_ONE = POS_W'(PIXEL_STEP);
  localparam logic [COE_WIDTH-1:0] COE_ONE  = COE_WIDTH'(coe_one(COE_WIDTH));
  localparam logic [SW-1:0]        ROUND    = SW'(round_add(COE_WIDTH));
  localparam logic [SW-1:0]        PIX_MAX  = SW'((1 << PIXEL_WIDTH) - 1);
  localparam logic [AW-1:0]        X_MAX    = AW'(LINE_MAX - 1);
`ifdef SCALER_V_TOP_ALIGN_EN
  localparam logic [POS_W-1:0]     CNT_O_INIT = '0;
`else
  localparam logic [POS_W-1:0]     CNT_O_INIT = STEP_ONE;
`endif

  logic [POS_W-1:0]     cnt_i, cnt_o, step_eff;
  logic                 frame_valid, sof_pend, line_emit, line_vs;
  logic [COE_WIDTH-1:0] line_coe;
  logic [AW-1:0]        x_q, x_n;

  logic                 frame_start, line_start, ovf_now, emit, sof_n;
  logic [POS_W-1:0]     ci, co, se, d, step_in;

  // Line-start decision uses the frame-start-reset view of the position counters.
  always_comb begin
    frame_start = de_i & hs_i & vs_i;
    line_start  = de_i & hs_i & (frame_valid | vs_i);
    step_in     = POS_W'(scale_step_v);
    ci          = frame_start ? '0 : cnt_i;
    co          = frame_start ? CNT_O_INIT : cnt_o;
    se          = step_eff;
    if (frame_start) se = (step_in < STEP_ONE) ? STEP_ONE : step_in;
    emit        = (ci >= co);
    d           = co - ci + STEP_ONE;
    sof_n       = frame_start | sof_pend;
    ovf_now     = de_i & ~hs_i & (x_q == X_MAX);
    if (hs_i)              x_n = '0;
    else if (x_q == X_MAX) x_n = x_q;
    else                   x_n = x_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_i       <= '0;
      cnt_o       <= '0;
      step_eff    <= '0;
      frame_valid <= 1'b0;
      sof_pend    <= 1'b0;
      line_emit   <= 1'b0;
      line_vs     <= 1'b0;
      line_coe    <= '0;
      x_q         <= '0;
      line_ovf_o  <= 1'b0;
    end else begin
      if (line_start) begin
        cnt_i     <= ci + STEP_ONE;
        cnt_o     <= emit ? co + se : co;
        step_eff  <= se;
        line_emit <= emit;
        line_coe  <= COE_WIDTH'(d >> SH);
        line_vs   <= emit & sof_n;
        sof_pend  <= sof_n & ~emit;
      end
      if (frame_start) frame_valid <= 1'b1;
      if (de_i) x_q <= x_n;
      if (frame_start)                line_ovf_o <= 1'b0;
      else if (ovf_now & frame_valid) line_ovf_o <= 1'b1;
    end
  end

  logic [PIXEL_WIDTH-1:0] s1_pix, s2_cur, ram_prev, prev_eff;
  logic [AW-1:0]          s1_x;
  logic                   s1_de, s1_hs, s1_ovf, s2_ovf, ram_we;
  logic [COE_WIDTH-1:0]   s2_coe, coe_prev;
  sync_t                  s2_sync, s3_sync, s4_sync;
  logic [PW-1:0]          p_prev, p_cur;
  logic [SW-1:0]          sum, sum_sh;

  // Overflowed columns have no buffered tap, so the current pixel stands in for it.
  always_comb begin
    ram_we   = s1_de & ~s1_ovf;
    prev_eff = s2_ovf ? s2_cur : ram_prev;
    coe_prev = COE_ONE - s2_coe;
    sum_sh   = sum >> (COE_WIDTH - 1);
  end

  scaler_line_ram #(
    .DEPTH (LINE_MAX),
    .WIDTH (PIXEL_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s1_x),
    .wdata (s1_pix),
    .raddr (s1_x),
    .rdata (ram_prev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pix  <= '0;
      s1_x    <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_ovf  <= 1'b0;
      s2_cur  <= '0;
      s2_ovf  <= 1'b0;
      s2_coe  <= '0;
      s2_sync <= '0;
      s3_sync <= '0;
      s4_sync <= '0;
      p_prev  <= '0;
      p_cur   <= '0;
      sum     <= '0;
      do_o    <= '0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
    end else begin
      s1_pix     <= di_i;
      s1_x       <= x_n;
      s1_de      <= de_i;
      s1_hs      <= de_i & hs_i;
      s1_ovf     <= ovf_now;
      s2_cur     <= s1_pix;
      s2_ovf     <= s1_ovf;
      s2_coe     <= line_coe;
      s2_sync.de <= s1_de & line_emit;
      s2_sync.hs <= s1_hs & line_emit;
      s2_sync.vs <= s1_hs & line_emit & line_vs;
      p_prev     <= PW'(coe_prev) * PW'(prev_eff);
      p_cur      <= PW'(s2_coe) * PW'(s2_cur);
      s3_sync    <= s2_sync;
      sum        <= SW'(p_prev) + SW'(p_cur) + ROUND;
      s4_sync    <= s3_sync;
      do_o       <= (sum_sh > PIX_MAX) ? PIX_MAX[PIXEL_WIDTH-1:0] : sum_sh[PIXEL_WIDTH-1:0];
      de_o       <= s4_sync.de;
      hs_o       <= s4_sync.hs;
      vs_o       <= s4_sync.vs;
    end
  end

endmodule

// File: tb/tb_scaler_v.sv
// tb/tb_scaler_v.sv - directed self-checking bench for scaler_v
module tb_scaler_v;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] scale_step_v = 16'd4096;
  logic [11:0] di_i = '0;
  logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [11:0] do_o, ovf_do;
  logic        de_o, hs_o, vs_o, line_ovf_o;
  logic        ovf_de, ovf_hs, ovf_vs, ovf_line_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int line_edge [8];
  logic [11:0] q_d [$];
  logic        q_hs [$];
  logic        q_vs [$];
  int          q_cyc [$];

  scaler_v u_dut (
    .clk(clk), .rst_n(rst_n), .scale_step_v(scale_step_v),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .line_ovf_o(line_ovf_o)
  );

  scaler_v #(.LINE_MAX(16)) u_ovf (
    .clk(clk), .rst_n(rst_n), .scale_step_v(scale_step_v),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(ovf_do), .de_o(ovf_de), .hs_o(ovf_hs), .vs_o(ovf_vs), .line_ovf_o(ovf_line_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (de_o) begin
      q_d.push_back(do_o);
      q_hs.push_back(hs_o);
      q_vs.push_back(vs_o);
      q_cyc.push_back(cyc);
    end
    if (ovf_de) ovf_cnt = ovf_cnt + 1;
  end

  function automatic logic [11:0] pix_val(input int mode, input int l, input int c);
    case (mode)
      0:       return 12'(100 * l);
      1:       return 12'(400 * l);
      2:       return 12'hFFF;
      default: return 12'(100 * l + c);
    endcase
  endfunction

  task automatic drive_px(input logic [11:0] v, input logic h, input logic s);
    @(negedge clk);
    di_i = v; de_i = 1'b1; hs_i = h; vs_i = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    end
  endtask

  task automatic send_frame(input int step, input int nl, input int np, input int mode, input bit gap);
    scale_step_v = 16'(step);
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < np; c++) begin
        drive_px(pix_val(mode, l, c), c == 0, (c == 0) && (l == 0));
        if (c == 0) line_edge[l] = cyc + 1;
        if (gap && c == 3) idle(1);
      end
    end
    idle(10);
  endtask

  task automatic test_reset();
    int b;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (do_o !== 12'd0) begin failures++; $display("FAIL reset_do got %0d want 0", do_o); end
    checks++; if (de_o !== 1'b0) begin failures++; $display("FAIL reset_de got %b want 0", de_o); end
    checks++; if (hs_o !== 1'b0) begin failures++; $display("FAIL reset_hs got %b want 0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin failures++; $display("FAIL reset_vs got %b want 0", vs_o); end
    checks++; if (line_ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", line_ovf_o); end
    rst_n = 1'b1;
    b = q_d.size();
    // Lines and a stray vs before any valid frame start must stay silent.
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 8; c++) drive_px(12'd50, c == 0, 1'b0);
    drive_px(12'd60, 1'b0, 1'b1);
    idle(10);
    checks++; if (q_d.size() - b !== 0) begin failures++; $display("FAIL pre_frame_out got %0d want 0", q_d.size() - b); end
  endtask

  task automatic test_step_unity();
    int b;
    b = q_d.size();
    send_frame(4096, 8, 16, 0, 1'b0);
    checks++; if (q_d.size() - b !== 112) begin failures++; $display("FAIL unity_count got %0d want 112", q_d.size() - b); end
    for (int i = 0; i < 112; i++) begin
      checks++; if (q_d[b+i] !== 12'(100 * (i / 16 + 1))) begin failures++; $display("FAIL unity_val[%0d] got %0d want %0d", i, q_d[b+i], 100 * (i / 16 + 1)); end
      checks++; if (q_hs[b+i] !== (i % 16 == 0)) begin failures++; $display("FAIL unity_hs[%0d] got %b", i, q_hs[b+i]); end
      checks++; if (q_vs[b+i] !== (i == 0)) begin failures++; $display("FAIL unity_vs[%0d] got %b", i, q_vs[b+i]); end
    end
    checks++; if (q_cyc[b] - line_edge[1] !== 4) begin failures++; $display("FAIL unity_latency got %0d want 4", q_cyc[b] - line_edge[1]); end
  endtask

  task automatic test_step_two();
    int b, nh, nv;
    b = q_d.size();
    send_frame(8192, 8, 16, 3, 1'b0);
    checks++; if (q_d.size() - b !== 64) begin failures++; $display("FAIL two_count got %0d want 64", q_d.size() - b); end
    nh = 0; nv = 0;
    for (int i = 0; i < 64; i++) begin
      nh += int'(q_hs[b+i]);
      nv += int'(q_vs[b+i]);
      checks++; if (q_d[b+i] !== 12'(100 * (2 * (i / 16) + 1) + i % 16)) begin failures++; $display("FAIL two_val[%0d] got %0d want %0d", i, q_d[b+i], 100 * (2 * (i / 16) + 1) + i % 16); end
    end
    checks++; if (nh !== 4) begin failures++; $display("FAIL two_hs_count got %0d want 4", nh); end
    checks++; if (nv !== 1) begin failures++; $display("FAIL two_vs_count got %0d want 1", nv); end
    checks++; if (q_cyc[b+16] - line_edge[3] !== 4) begin failures++; $display("FAIL two_latency got %0d want 4", q_cyc[b+16] - line_edge[3]); end
  endtask

  task automatic test_step_mix();
    int b;
    b = q_d.size();
    // Line 3 lands halfway between input lines 2 and 3: (256*800 + 256*1200 + 256) >> 9 = 1000.
    send_frame(6144, 4, 8, 1, 1'b1);
    checks++; if (q_d.size() - b !== 16) begin failures++; $display("FAIL mix_count got %0d want 16", q_d.size() - b); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (q_d[b+i] !== ((i < 8) ? 12'd400 : 12'd1000)) begin failures++; $display("FAIL mix_val[%0d] got %0d want %0d", i, q_d[b+i], (i < 8) ? 400 : 1000); end
    end
  endtask

  task automatic test_upscale_sat();
    int b;
    b = q_d.size();
    send_frame(2048, 4, 4, 0, 1'b0);
    checks++; if (q_d.size() - b !== 12) begin failures++; $display("FAIL up_count got %0d want 12", q_d.size() - b); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (q_d[b+i] !== 12'(100 * (i / 4 + 1))) begin failures++; $display("FAIL up_val[%0d] got %0d want %0d", i, q_d[b+i], 100 * (i / 4 + 1)); end
    end
    b = q_d.size();
    send_frame(6144, 4, 4, 2, 1'b0);
    checks++; if (q_d.size() - b !== 8) begin failures++; $display("FAIL sat_count got %0d want 8", q_d.size() - b); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (q_d[b+i] !== 12'd4095) begin failures++; $display("FAIL sat_val[%0d] got %0d want 4095", i, q_d[b+i]); end
    end
  endtask

  task automatic test_line_ovf();
    int b, bo;
    b = q_d.size();
    bo = ovf_cnt;
    send_frame(4096, 3, 20, 0, 1'b0);
    checks++; if (ovf_line_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b want 1", ovf_line_ovf); end
    checks++; if (line_ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_wide_clear got %b want 0", line_ovf_o); end
    checks++; if (ovf_cnt - bo !== 40) begin failures++; $display("FAIL ovf_stream got %0d want 40", ovf_cnt - bo); end
    checks++; if (q_d.size() - b !== 40) begin failures++; $display("FAIL ovf_wide_count got %0d want 40", q_d.size() - b); end
    checks++; if (q_d[b+39] !== 12'd200) begin failures++; $display("FAIL ovf_wide_last got %0d want 200", q_d[b+39]); end
    send_frame(4096, 1, 4, 0, 1'b0);
    checks++; if (ovf_line_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", ovf_line_ovf); end
  endtask

  task automatic test_reset_midline();
    int b, nv;
    scale_step_v = 16'd4096;
    for (int c = 0; c < 16; c++) drive_px(12'd0, c == 0, c == 0);
    for (int c = 0; c < 10; c++) drive_px(12'd100, c == 0, 1'b0);
    checks++; if (de_o !== 1'b1) begin failures++; $display("FAIL mid_active got %b want 1", de_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (do_o !== 12'd0) begin failures++; $display("FAIL mid_rst_do got %0d want 0", do_o); end
    checks++; if (de_o !== 1'b0) begin failures++; $display("FAIL mid_rst_de got %b want 0", de_o); end
    checks++; if ({hs_o, vs_o} !== 2'b00) begin failures++; $display("FAIL mid_rst_sync got %b want 00", {hs_o, vs_o}); end
    idle(2);
    rst_n = 1'b1;
    b = q_d.size();
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 8; c++) drive_px(12'd200, c == 0, 1'b0);
    idle(10);
    checks++; if (q_d.size() - b !== 0) begin failures++; $display("FAIL mid_idle got %0d want 0", q_d.size() - b); end
    b = q_d.size();
    send_frame(4096, 2, 8, 0, 1'b0);
    checks++; if (q_d.size() - b !== 8) begin failures++; $display("FAIL mid_resume_count got %0d want 8", q_d.size() - b); end
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      nv += int'(q_vs[b+i]);
      checks++; if (q_d[b+i] !== 12'd100) begin failures++; $display("FAIL mid_resume_val[%0d] got %0d want 100", i, q_d[b+i]); end
    end
    checks++; if (nv !== 1) begin failures++; $display("FAIL mid_resume_vs got %0d want 1", nv); end
  endtask

  initial begin
    test_reset();
    test_step_unity();
    test_step_two();
    test_step_mix();
    test_upscale_sat();
    test_line_ovf();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
